// File: rtl/dvi_pixel_out_if.sv
// dvi_pixel_out_if: FIFO-side and DVI-side signals of the pixel output stage
interface dvi_pixel_out_if;
  logic        enable;
  logic [23:0] fifo_dout;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [23:0] pix_data;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic        frame_start;
  logic        underflow;
  modport master (
    input  enable, fifo_dout, fifo_empty,
    output fifo_rd_en, pix_data, de, hsync, vsync, frame_start, underflow
  );
  modport slave (
    output enable, fifo_dout, fifo_empty,
    input  fifo_rd_en, pix_data, de, hsync, vsync, frame_start, underflow
  );
endinterface

// File: rtl/dvi_pixel_out.sv
// dvi_pixel_out: raster timing generator that drains the pixel FIFO one word per active pixel
module dvi_pixel_out #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input logic             clk,
  input logic             RST,
  dvi_pixel_out_if.master bus
);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] HS_B   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_E   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] VS_B   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_E   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0] state_q, state_d;
  logic [9:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic       rd_q, rd_d, de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic       frame_start_q, frame_start_d, underflow_q, underflow_d;
  logic       run, h_end, v_end, act, hs, vs;
  always_comb begin
    run           = state_q == RUN;
    h_end         = h_cnt_q == H_LAST;
    v_end         = v_cnt_q == V_LAST;
    act           = run && h_cnt_q < H_ACT && v_cnt_q < V_ACT;
    hs            = run && h_cnt_q >= HS_B && h_cnt_q < HS_E;
    vs            = run && v_cnt_q >= VS_B && v_cnt_q < VS_E;
    // enable is only honoured at the frame boundary so a frame is never cut short
    state_d       = run ? ((h_end && v_end && !bus.enable) ? IDLE : RUN) : (bus.enable ? RUN : IDLE);
    h_cnt_d       = (!run || h_end) ? 10'd0 : h_cnt_q + 10'd1;
    v_cnt_d       = !run ? 10'd0 : h_end ? (v_end ? 10'd0 : v_cnt_q + 10'd1) : v_cnt_q;
    rd_d          = act && !bus.fifo_empty;
    de_d          = act;
    hsync_d       = hs ? SYNC_POL : ~SYNC_POL;
    vsync_d       = vs ? SYNC_POL : ~SYNC_POL;
    frame_start_d = run && h_cnt_q == 10'd0 && v_cnt_q == 10'd0;
    underflow_d   = underflow_q | (act && bus.fifo_empty);
  end
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      rd_q          <= 1'b0;
      de_q          <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      rd_q          <= rd_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
    end
  end
  // fifo_dout is the FIFO's own output register; rd_q selects it in the cycle its word is valid
  assign bus.fifo_rd_en  = rd_d;
  assign bus.pix_data    = rd_q ? bus.fifo_dout : 24'h0;
  assign bus.de          = de_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.frame_start = frame_start_q;
  assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_dvi_pixel_out.sv
// tb_dvi_pixel_out: directed checks of raster timing, FIFO draining and underflow on a shrunken raster
module tb_dvi_pixel_out;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2, HT = HA + HF + HS + HB;
  localparam int VA = 4, VF = 1, VS = 2, VB = 2, VT = VA + VF + VS + VB;
  logic clk = 1'b0;
  logic RST = 1'b1;
  always #5 clk = ~clk;
  dvi_pixel_out_if bus();
  dvi_pixel_out #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk),
    .RST(RST),
    .bus(bus)
  );
  int total = 0, bad = 0;
  int cyc = 0, last_fs = 0;
  logic [23:0] fcnt;
  // standard-latency FIFO holding an incrementing count
  always @(posedge clk or posedge RST)
    if (RST) begin
      fcnt          <= 24'd0;
      bus.fifo_dout <= 24'hABCDEF;
    end else if (bus.fifo_rd_en) begin
      bus.fifo_dout <= fcnt;
      fcnt          <= fcnt + 24'd1;
    end
  logic        run_m = 1'b0, uf_m = 1'b0;
  int          hc = 0, vc = 0, nwords = 0;
  logic [4:0]  exp_v;
  logic [23:0] exp_pix;
  function automatic logic act(int h, int v);
    return h < HA && v < VA;
  endfunction
  // advances one clock; exp_v = {de,hsync,vsync,frame_start,underflow} expected after the edge
  task automatic step();
    logic a, r;
    a = run_m && act(hc, vc);
    r = a && !bus.fifo_empty;
    exp_v = {a, ~(run_m && hc >= HA + HF && hc < HA + HF + HS),
             ~(run_m && vc >= VA + VF && vc < VA + VF + VS),
             run_m && hc == 0 && vc == 0, uf_m | (a && bus.fifo_empty)};
    uf_m = exp_v[0];
    exp_pix = r ? 24'(nwords) : 24'h0;
    if (r) nwords++;
    @(posedge clk);
    cyc++;
    if (!run_m) begin
      run_m = bus.enable; hc = 0; vc = 0;
    end else if (hc == HT - 1) begin
      hc = 0;
      if (vc == VT - 1) begin vc = 0; run_m = bus.enable; end
      else vc++;
    end else hc++;
    @(negedge clk);
  endtask
  task automatic test_reset();
    bus.enable = 1'b0; bus.fifo_empty = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ({bus.de, bus.hsync, bus.vsync, bus.frame_start, bus.underflow} !== 5'b01100) begin bad++; $display("FAIL reset_ctl got=%b exp=01100", {bus.de, bus.hsync, bus.vsync, bus.frame_start, bus.underflow}); end
    total++; if (bus.pix_data !== 24'h0) begin bad++; $display("FAIL reset_pix got=%h exp=000000", bus.pix_data); end
    total++; if (bus.fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd got=%b exp=0", bus.fifo_rd_en); end
    RST = 1'b0;
    repeat (3) begin
      #1; total++; if (bus.fifo_rd_en !== 1'b0) begin bad++; $display("FAIL idle_rd cyc=%0d got=%b exp=0", cyc, bus.fifo_rd_en); end
      step();
      total++; if ({bus.de, bus.hsync, bus.vsync, bus.frame_start, bus.underflow} !== exp_v) begin bad++; $display("FAIL idle_ctl cyc=%0d got=%b exp=%b", cyc, {bus.de, bus.hsync, bus.vsync, bus.frame_start, bus.underflow}, exp_v); end
    end
  endtask
  task automatic test_line_timing();
    int rds = 0, des = 0, hlow = 0;
    logic seen = 1'b0;
    bus.enable = 1'b1;
    repeat (HT * VT) begin
      #1; total++; if (bus.fifo_rd_en !== (run_m && act(hc, vc) && !bus.fifo_empty)) begin bad++; $display("FAIL line_rd cyc=%0d got=%b", cyc, bus.fifo_rd_en); end
      rds += int'(bus.fifo_rd_en);
      step();
      total++; if ({bus.de, bus.hsync, bus.vsync, bus.frame_start, bus.underflow} !== exp_v) begin bad++; $display("FAIL line_ctl cyc=%0d got=%b exp=%b", cyc, {bus.de, bus.hsync, bus.vsync, bus.frame_start, bus.underflow}, exp_v); end
      total++; if (bus.pix_data !== exp_pix) begin bad++; $display("FAIL line_pix cyc=%0d got=%h exp=%h", cyc, bus.pix_data, exp_pix); end
      if (bus.de === 1'b1 && !seen) begin
        seen = 1'b1;
        total++; if (bus.pix_data !== 24'h0) begin bad++; $display("FAIL first_word got=%h exp=000000", bus.pix_data); end
      end
      des += int'(bus.de);
      hlow += int'(!bus.hsync);
      if (bus.frame_start) last_fs = cyc;
    end
    total++; if (rds != HA * VA) begin bad++; $display("FAIL frame_reads got=%0d exp=%0d", rds, HA * VA); end
    total++; if (des != HA * VA) begin bad++; $display("FAIL frame_de got=%0d exp=%0d", des, HA * VA); end
    total++; if (hlow != HS * VT) begin bad++; $display("FAIL hsync_low got=%0d exp=%0d", hlow, HS * VT); end
  endtask
  task automatic test_frame_timing();
    int vlow = 0, fs_n = 0, rds = 0;
    repeat (HT * VT) begin
      #1; total++; if (bus.fifo_rd_en !== (run_m && act(hc, vc) && !bus.fifo_empty)) begin bad++; $display("FAIL frame_rd cyc=%0d got=%b", cyc, bus.fifo_rd_en); end
      rds += int'(bus.fifo_rd_en);
      step();
      total++; if ({bus.de, bus.hsync, bus.vsync, bus.frame_start, bus.underflow} !== exp_v) begin bad++; $display("FAIL frame_ctl cyc=%0d got=%b exp=%b", cyc, {bus.de, bus.hsync, bus.vsync, bus.frame_start, bus.underflow}, exp_v); end
      total++; if (bus.pix_data !== exp_pix) begin bad++; $display("FAIL frame_pix cyc=%0d got=%h exp=%h", cyc, bus.pix_data, exp_pix); end
      vlow += int'(!bus.vsync);
      if (bus.frame_start) begin
        fs_n++;
        total++; if (cyc - last_fs != HT * VT) begin bad++; $display("FAIL fs_period got=%0d exp=%0d", cyc - last_fs, HT * VT); end
        last_fs = cyc;
      end
    end
    total++; if (vlow != VS * HT) begin bad++; $display("FAIL vsync_low got=%0d exp=%0d", vlow, VS * HT); end
    total++; if (fs_n != 1) begin bad++; $display("FAIL fs_count got=%0d exp=1", fs_n); end
    total++; if (rds != HA * VA) begin bad++; $display("FAIL frame2_reads got=%0d exp=%0d", rds, HA * VA); end
  endtask
  task automatic test_underflow();
    int black = 0, rd_hole = 0;
    repeat (HT * VT) begin
      bus.fifo_empty = run_m && vc == 2 && hc >= 1 && hc <= 5;
      #1; total++; if (bus.fifo_rd_en !== (run_m && act(hc, vc) && !bus.fifo_empty)) begin bad++; $display("FAIL uf_rd cyc=%0d got=%b", cyc, bus.fifo_rd_en); end
      rd_hole += int'(bus.fifo_empty && bus.fifo_rd_en);
      step();
      total++; if ({bus.de, bus.hsync, bus.vsync, bus.frame_start, bus.underflow} !== exp_v) begin bad++; $display("FAIL uf_ctl cyc=%0d got=%b exp=%b", cyc, {bus.de, bus.hsync, bus.vsync, bus.frame_start, bus.underflow}, exp_v); end
      total++; if (bus.pix_data !== exp_pix) begin bad++; $display("FAIL uf_pix cyc=%0d got=%h exp=%h", cyc, bus.pix_data, exp_pix); end
      black += int'(bus.de === 1'b1 && bus.pix_data === 24'h0);
    end
    bus.fifo_empty = 1'b0;
    total++; if (rd_hole != 0) begin bad++; $display("FAIL uf_no_read got=%0d exp=0", rd_hole); end
    total++; if (black != 5) begin bad++; $display("FAIL uf_black got=%0d exp=5", black); end
    total++; if (bus.underflow !== 1'b1) begin bad++; $display("FAIL uf_flag got=%b exp=1", bus.underflow); end
  endtask
  task automatic test_enable_drop();
    int des = 0, rds = 0;
    for (int i = 0; i < HT * VT + 10; i++) begin
      if (i == 20) bus.enable = 1'b0;
      #1; total++; if (bus.fifo_rd_en !== (run_m && act(hc, vc) && !bus.fifo_empty)) begin bad++; $display("FAIL drop_rd cyc=%0d got=%b", cyc, bus.fifo_rd_en); end
      rds += int'(bus.fifo_rd_en);
      step();
      total++; if ({bus.de, bus.hsync, bus.vsync, bus.frame_start, bus.underflow} !== exp_v) begin bad++; $display("FAIL drop_ctl cyc=%0d got=%b exp=%b", cyc, {bus.de, bus.hsync, bus.vsync, bus.frame_start, bus.underflow}, exp_v); end
      total++; if (bus.pix_data !== exp_pix) begin bad++; $display("FAIL drop_pix cyc=%0d got=%h exp=%h", cyc, bus.pix_data, exp_pix); end
      des += int'(bus.de);
    end
    total++; if (des != HA * VA) begin bad++; $display("FAIL drop_full_frame got=%0d exp=%0d", des, HA * VA); end
    total++; if (rds != HA * VA) begin bad++; $display("FAIL drop_reads got=%0d exp=%0d", rds, HA * VA); end
    total++; if ({bus.de, bus.hsync, bus.vsync, bus.fifo_rd_en} !== 4'b0110) begin bad++; $display("FAIL drop_idle got=%b exp=0110", {bus.de, bus.hsync, bus.vsync, bus.fifo_rd_en}); end
    bus.enable = 1'b1;
    step();
    #1; total++; if (bus.fifo_rd_en !== 1'b1) begin bad++; $display("FAIL restart_rd got=%b exp=1", bus.fifo_rd_en); end
    step();
    total++; if ({bus.de, bus.frame_start, bus.underflow} !== 3'b111) begin bad++; $display("FAIL restart_fs got=%b exp=111", {bus.de, bus.frame_start, bus.underflow}); end
    total++; if (bus.pix_data !== exp_pix) begin bad++; $display("FAIL restart_pix got=%h exp=%h", bus.pix_data, exp_pix); end
  endtask
  task automatic test_reset_midline();
    repeat (5) step();
    RST = 1'b1;
    #1;
    total++; if ({bus.de, bus.hsync, bus.vsync, bus.frame_start, bus.underflow} !== 5'b01100) begin bad++; $display("FAIL rst_mid_ctl got=%b exp=01100", {bus.de, bus.hsync, bus.vsync, bus.frame_start, bus.underflow}); end
    total++; if (bus.pix_data !== 24'h0) begin bad++; $display("FAIL rst_mid_pix got=%h exp=000000", bus.pix_data); end
    total++; if (bus.fifo_rd_en !== 1'b0) begin bad++; $display("FAIL rst_mid_rd got=%b exp=0", bus.fifo_rd_en); end
    run_m = 1'b0; hc = 0; vc = 0; uf_m = 1'b0; nwords = 0;
    @(negedge clk);
    RST = 1'b0;
    repeat (20) begin
      #1; total++; if (bus.fifo_rd_en !== (run_m && act(hc, vc) && !bus.fifo_empty)) begin bad++; $display("FAIL rerun_rd cyc=%0d got=%b", cyc, bus.fifo_rd_en); end
      step();
      total++; if ({bus.de, bus.hsync, bus.vsync, bus.frame_start, bus.underflow} !== exp_v) begin bad++; $display("FAIL rerun_ctl cyc=%0d got=%b exp=%b", cyc, {bus.de, bus.hsync, bus.vsync, bus.frame_start, bus.underflow}, exp_v); end
      total++; if (bus.pix_data !== exp_pix) begin bad++; $display("FAIL rerun_pix cyc=%0d got=%h exp=%h", cyc, bus.pix_data, exp_pix); end
    end
  endtask
  initial begin
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_underflow();
    test_enable_drop();
    test_reset_midline();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dvi_pixel_out.md
# dvi_pixel_out

Pixel-clock-domain output stage that drains the 24-bit pixel FIFO and generates 640x480@60 raster timing (HSYNC, VSYNC, DE) for the DVI transmitter. It sits directly downstream of the async pixel FIFO, clocked by the 25 MHz DCM output. It starts scanning only once DVI I2C configuration reports done. It reads exactly one FIFO word per active pixel, aligned to DE. It flags, but survives, FIFO underflow.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch; H_TOTAL = 800
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch; V_TOTAL = 525
- SYNC_POL, 0, sync asserted level (0 = active-low)

Ports:
- clk  in  1  pixel clock (25 MHz)
- RST  in  1  reset, asynchronous, active-high
- enable  in  1  start scanning (DVI config done); level
- fifo_dout  in  24  FIFO read data, valid the cycle after fifo_rd_en
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_en  out  1  FIFO read strobe (combinational from registered state)
- pix_data  out  24  registered pixel {R[7:0],G[7:0],B[7:0]}
- de  out  1  registered data enable
- hsync  out  1  registered horizontal sync
- vsync  out  1  registered vertical sync
- frame_start  out  1  one-cycle pulse coincident with first active pixel of a frame
- underflow  out  1  sticky: FIFO was empty when an active pixel was due

## Operation
- Counters h_cnt (10 bit, 0..H_TOTAL-1) and v_cnt (10 bit, 0..V_TOTAL-1). h_cnt wraps to 0 at H_TOTAL-1. v_cnt increments on h wrap and wraps to 0 at V_TOTAL-1.
- State machine has two states:
  - IDLE: counters held at 0, fifo_rd_en=0, outputs at inactive values. Exits to RUN on the first clk with enable=1; h_cnt=0,v_cnt=0 on the next cycle.
  - RUN: counters free-run. enable=0 is sampled only at the end of a frame (h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1). If enable=0 there, go to IDLE; otherwise wrap and continue. An enable drop mid-frame never truncates the frame.
- Pre-decode signals (from counters, RUN only):
  - act = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE
  - hs = H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751)
  - vs = V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491)
- fifo_rd_en = RUN && act && !fifo_empty.
- Registered outputs, all updated each clk:
  - de <= act
  - hsync <= hs ? SYNC_POL : ~SYNC_POL
  - vsync <= vs ? SYNC_POL : ~SYNC_POL
  - frame_start <= RUN && h_cnt==0 && v_cnt==0
  - pix_data: see underflow handling below
- Underflow handling:
  - Track rd_q = registered fifo_rd_en.
  - pix_data <= 24'h0 when de would be 0. Otherwise pix_data takes the FIFO word if that pixel's read was issued; if it was not issued, pix_data is 24'h000000 (black).
  - Implementation: pipeline act and fifo_rd_en one stage. Output register muxes fifo_dout when rd_q, else 0.
  - underflow <= 1 whenever act && fifo_empty in RUN; it is cleared only by RST.
  - After an underflow the raster never stalls; pixel positions slip relative to FIFO content, and software/bench treats underflow as a fatal flag.

## Timing
- Reset values (RST high, async):
  - state=IDLE, h_cnt=0, v_cnt=0
  - de=0, pix_data=0, hsync=vsync=~SYNC_POL (1 with defaults)
  - frame_start=0, underflow=0, fifo_rd_en=0
- Latency: counter value to outputs = 1 clk. fifo_rd_en at cycle N produces the matching pix_data with de=1 at cycle N+1, which matches FIFO standard (non-FWFT) read latency.
- Line is 800 clks, with de high for 640 consecutive clks. hsync is asserted for 96 clks, starting 656 clks after de rises.
- Frame is 525 lines = 420000 clks. vsync is asserted for 2 full lines (1600 clks), starting at line 490, h_cnt=0.
- frame_start rises together with the first de of a frame, exactly 420000 clks apart.
- RST mid-frame: outputs take reset values immediately (asynchronously). Restart requires enable with RST low, from h=0,v=0.

## Test plan
- Reset check: assert RST mid-line → all outputs at reset values in the same cycle, underflow cleared, fifo_rd_en=0.
- Line timing: enable=1, FIFO never empty → de high 640 clks per 800. hsync low on h_cnt 656..751 (outputs one clk later). Exactly 640 rd_en pulses per active line.
- Frame timing: run 2 frames → 307200 reads per frame. vsync low for 1600 clks starting at line 490. frame_start pulses 420000 clks apart.
- Data alignment: FIFO model returns an incrementing count → pix_data on consecutive de cycles = 0,1,2,…,639 on line 0. The first de cycle carries word 0.
- Underflow: force fifo_empty=1 for 5 active pixels on line 10 → no rd_en on those cycles, pix_data=0 with de=1 there, underflow latches 1 and stays 1 through later frames.
- Enable drop: deassert enable at line 100 → frame completes all 525 lines, then IDLE (de=0, syncs inactive, no reads). Re-asserting enable restarts at h=0,v=0 with frame_start on the first de.
